// File: rtl/vend_pkg.sv
// Shared state encoding and price table for the vending-machine controller.
package vend_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_DIGIT1 = 3'd1;
  localparam state_t ST_DIGIT2 = 3'd2;
  localparam state_t ST_PAY    = 3'd3;
  localparam state_t ST_VEND   = 3'd4;
  localparam state_t ST_DOOR   = 3'd5;

  // Price by slot index; anything outside the priced range costs the maximum.
  function automatic int vend_cost(input int idx, input int cost_w);
    int raw;
    int max_c;
    max_c = (1 << cost_w) - 1;
    if (idx < 4)       raw = 1;
    else if (idx < 8)  raw = 2;
    else if (idx < 12) raw = 3;
    else if (idx < 16) raw = 4;
    else if (idx < 18) raw = 5;
    else if (idx < 20) raw = 6;
    else               raw = max_c;
    return (raw > max_c) ? max_c : raw;
  endfunction

endpackage

// File: rtl/vend_timer.sv
// Idle-cycle counter shared by all waiting states; expire flags the last allowed cycle.
module vend_timer #(
  parameter int TIMEOUT = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT);

  logic [TW-1:0] cnt_q, cnt_d;

  assign expire = (cnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q + TW'(1);
    if (clr || expire) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vending_machine_param.sv
// Vending-machine controller: card, two-digit selection, payment, vend and door phases
// with per-slot stock counters and a shared idle timeout.
module vending_machine_param
  import vend_pkg::*;
#(
  parameter int N_ITEMS    = 20,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 10,
  parameter int TIMEOUT    = 5,
  parameter int COST_W     = 3
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               RELOAD,
  input  logic               CARD_IN,
  input  logic [3:0]         ITEM_CODE,
  input  logic               KEY_PRESS,
  input  logic               CANCEL,
  input  logic               VALID_TRAN,
  input  logic               DOOR_OPEN,
  output logic               VEND,
  output logic               INVALID_SEL,
  output logic               FAILED_TRAN,
  output logic [COST_W-1:0]  COST,
  output logic [N_ITEMS-1:0] SOLD_OUT
);

  state_t              state_q, state_d;
  logic [3:0]          tens_q, tens_d;
  logic [6:0]          idx_q, idx_d;
  logic [STOCK_W-1:0]  stock_q [N_ITEMS];
  logic [STOCK_W-1:0]  stock_d [N_ITEMS];
  logic                vend_q, vend_d;
  logic                inv_q, inv_d;
  logic                fail_q, fail_d;
  logic [COST_W-1:0]   cost_q, cost_d;
  logic                key_acc, timer_clr, expire;
  int                  sel_idx;
  logic [STOCK_W-1:0]  sel_stock;

  vend_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (CLK),
    .rst_n  (RST_N),
    .clr    (timer_clr),
    .expire (expire)
  );

  always_comb begin
    state_d   = state_q;
    tens_d    = tens_q;
    idx_d     = idx_q;
    stock_d   = stock_q;
    inv_d     = 1'b0;
    fail_d    = 1'b0;
    cost_d    = cost_q;
    key_acc   = 1'b0;
    sel_idx   = int'(tens_q) * 10 + int'(ITEM_CODE);
    sel_stock = '0;
    for (int i = 0; i < N_ITEMS; i++)
      if (sel_idx == i) sel_stock = stock_q[i];

    case (state_q)
      ST_IDLE: begin
        if (RELOAD) begin
          for (int i = 0; i < N_ITEMS; i++) stock_d[i] = STOCK_W'(INIT_STOCK);
        end else if (CARD_IN) begin
          state_d = ST_DIGIT1;
        end
      end
      ST_DIGIT1: begin
        if (CANCEL) state_d = ST_IDLE;
        else if (KEY_PRESS) begin
          key_acc = 1'b1;
          tens_d  = ITEM_CODE;
          state_d = ST_DIGIT2;
        end else if (expire) begin
          inv_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DIGIT2: begin
        if (CANCEL) state_d = ST_IDLE;
        else if (KEY_PRESS) begin
          key_acc = 1'b1;
          // Both digits are range-checked separately so codes like 0,15 cannot alias slot 15.
          if (ITEM_CODE > 4'd9 || tens_q > 4'd9 || sel_idx >= N_ITEMS || sel_stock == '0) begin
            inv_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d   = 7'(sel_idx);
            cost_d  = COST_W'(vend_cost(sel_idx, COST_W));
            state_d = ST_PAY;
          end
        end else if (expire) begin
          inv_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_PAY: begin
        if (CANCEL) state_d = ST_IDLE;
        else if (VALID_TRAN) begin
          for (int i = 0; i < N_ITEMS; i++)
            if (int'(idx_q) == i && stock_q[i] != '0) stock_d[i] = stock_q[i] - STOCK_W'(1);
          state_d = ST_VEND;
        end else if (expire) begin
          fail_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_VEND: begin
        if (DOOR_OPEN)   state_d = ST_DOOR;
        else if (expire) state_d = ST_IDLE;
      end
      ST_DOOR: begin
        if (!DOOR_OPEN) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) cost_d = '0;
    vend_d    = (state_d == ST_VEND) || (state_d == ST_DOOR);
    timer_clr = (state_d != state_q) || key_acc;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      tens_q  <= '0;
      idx_q   <= '0;
      vend_q  <= 1'b0;
      inv_q   <= 1'b0;
      fail_q  <= 1'b0;
      cost_q  <= '0;
      for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= '0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      idx_q   <= idx_d;
      vend_q  <= vend_d;
      inv_q   <= inv_d;
      fail_q  <= fail_d;
      cost_q  <= cost_d;
      stock_q <= stock_d;
    end
  end

  always_comb begin
    SOLD_OUT = '0;
    for (int i = 0; i < N_ITEMS; i++) SOLD_OUT[i] = (stock_q[i] == '0);
  end

  assign VEND        = vend_q;
  assign INVALID_SEL = inv_q;
  assign FAILED_TRAN = fail_q;
  assign COST        = cost_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Scenario bench for vending_machine_param: expected outputs are queued per driven cycle
// and popped against the registered DUT response one cycle later.
module tb_vending_machine_param;

  logic        CLK, RST_N, RELOAD, CARD_IN, KEY_PRESS, CANCEL, VALID_TRAN, DOOR_OPEN;
  logic [3:0]  ITEM_CODE;
  logic        VEND, INVALID_SEL, FAILED_TRAN;
  logic [2:0]  COST;
  logic [19:0] SOLD_OUT;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       reload;
    logic       card;
    logic       key;
    logic [3:0] code;
    logic       cancel;
    logic       valid;
    logic       door;
  } stim_t;

  typedef struct packed {
    logic        vend;
    logic        inv;
    logic        fail;
    logic [2:0]  cost;
    logic [19:0] so;
  } out_t;

  localparam logic [19:0] ALL = 20'hFFFFF;
  localparam logic [19:0] NO  = 20'h00000;

  out_t exp_q[$];

  vending_machine_param dut (
    .CLK(CLK), .RST_N(RST_N), .RELOAD(RELOAD), .CARD_IN(CARD_IN), .ITEM_CODE(ITEM_CODE),
    .KEY_PRESS(KEY_PRESS), .CANCEL(CANCEL), .VALID_TRAN(VALID_TRAN), .DOOR_OPEN(DOOR_OPEN),
    .VEND(VEND), .INVALID_SEL(INVALID_SEL), .FAILED_TRAN(FAILED_TRAN), .COST(COST),
    .SOLD_OUT(SOLD_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic stim_t stm(input logic rl, cd, kp, input logic [3:0] c,
                                input logic cn, vt, dr);
    stim_t s;
    s = '{reload: rl, card: cd, key: kp, code: c, cancel: cn, valid: vt, door: dr};
    return s;
  endfunction

  function automatic out_t exo(input logic v, i, f, input logic [2:0] c, input logic [19:0] so);
    out_t o;
    o = '{vend: v, inv: i, fail: f, cost: c, so: so};
    return o;
  endfunction

  function automatic out_t observed();
    out_t o;
    o = '{vend: VEND, inv: INVALID_SEL, fail: FAILED_TRAN, cost: COST, so: SOLD_OUT};
    return o;
  endfunction

  task automatic drive(input stim_t s, input out_t e);
    RELOAD = s.reload; CARD_IN = s.card; KEY_PRESS = s.key; ITEM_CODE = s.code;
    CANCEL = s.cancel; VALID_TRAN = s.valid; DOOR_OPEN = s.door;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    {RELOAD, CARD_IN, KEY_PRESS, CANCEL, VALID_TRAN, DOOR_OPEN} = '0;
    ITEM_CODE = '0;
  endtask

  stim_t IDLE_S;
  assign IDLE_S = '0;

  task automatic test_reset();
    out_t got;
    RST_N = 1'b0;
    {RELOAD, CARD_IN, KEY_PRESS, CANCEL, VALID_TRAN, DOOR_OPEN} = '0;
    ITEM_CODE = '0;
    #3;
    got = observed(); checks++;
    if (got !== exo(0, 0, 0, 0, ALL)) begin
      errors++; $display("FAIL reset_async got %h want %h", got, exo(0, 0, 0, 0, ALL));
    end
    repeat (2) @(posedge CLK);
    #1;
    got = observed(); checks++;
    if (got !== exo(0, 0, 0, 0, ALL)) begin
      errors++; $display("FAIL reset_held got %h want %h", got, exo(0, 0, 0, 0, ALL));
    end
    RST_N = 1'b1;
  endtask

  task automatic test_purchase();
    stim_t st[$]; out_t ex[$]; out_t got, want;
    st.push_back(stm(1,0,0,0,0,0,0)); ex.push_back(exo(0,0,0,0,NO));
    st.push_back(stm(0,1,0,0,0,0,0)); ex.push_back(exo(0,0,0,0,NO));
    st.push_back(stm(0,0,1,1,0,0,0)); ex.push_back(exo(0,0,0,0,NO));
    st.push_back(stm(0,0,1,2,0,0,0)); ex.push_back(exo(0,0,0,4,NO));
    st.push_back(stm(0,0,0,0,0,1,0)); ex.push_back(exo(1,0,0,4,NO));
    st.push_back(stm(0,0,0,0,0,0,1)); ex.push_back(exo(1,0,0,4,NO));
    st.push_back(stm(0,0,0,0,0,0,1)); ex.push_back(exo(1,0,0,4,NO));
    st.push_back(stm(0,0,0,0,0,0,0)); ex.push_back(exo(0,0,0,0,NO));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i], ex[i]);
      want = exp_q.pop_front(); got = observed(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL purchase step %0d got %h want %h", i, got, want);
      end
    end
    checks++;
    if (dut.stock_q[12] !== 4'd9) begin
      errors++; $display("FAIL purchase_stock12 got %0d want 9", dut.stock_q[12]);
    end
  endtask

  task automatic test_invalid_code();
    stim_t st[$]; out_t ex[$]; out_t got, want;
    RST_N = 1'b0; #3;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    st.push_back(stm(0,1,0,0,0,0,0)); ex.push_back(exo(0,0,0,0,ALL));
    st.push_back(stm(0,0,1,0,0,0,0)); ex.push_back(exo(0,0,0,0,ALL));
    st.push_back(stm(0,0,1,3,0,0,0)); ex.push_back(exo(0,1,0,0,ALL));
    st.push_back(IDLE_S);             ex.push_back(exo(0,0,0,0,ALL));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i], ex[i]);
      want = exp_q.pop_front(); got = observed(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL sold_out_sel step %0d got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_bad_index();
    stim_t st[$]; out_t ex[$]; out_t got, want;
    st.push_back(stm(1,0,0,0,0,0,0));  ex.push_back(exo(0,0,0,0,NO));
    st.push_back(stm(0,1,0,0,0,0,0));  ex.push_back(exo(0,0,0,0,NO));
    st.push_back(stm(0,0,1,2,0,0,0));  ex.push_back(exo(0,0,0,0,NO));
    st.push_back(stm(0,0,1,5,0,0,0));  ex.push_back(exo(0,1,0,0,NO));
    st.push_back(IDLE_S);              ex.push_back(exo(0,0,0,0,NO));
    st.push_back(stm(0,1,0,0,0,0,0));  ex.push_back(exo(0,0,0,0,NO));
    st.push_back(stm(0,0,1,2,0,0,0));  ex.push_back(exo(0,0,0,0,NO));
    st.push_back(stm(0,0,1,0,0,0,0));  ex.push_back(exo(0,1,0,0,NO));
    st.push_back(stm(0,1,0,0,0,0,0));  ex.push_back(exo(0,0,0,0,NO));
    st.push_back(stm(0,0,1,0,0,0,0));  ex.push_back(exo(0,0,0,0,NO));
    st.push_back(stm(0,0,1,10,0,0,0)); ex.push_back(exo(0,1,0,0,NO));
    st.push_back(stm(0,1,0,0,0,0,0));  ex.push_back(exo(0,0,0,0,NO));
    st.push_back(stm(0,0,1,1,0,0,0));  ex.push_back(exo(0,0,0,0,NO));
    st.push_back(stm(0,0,1,9,0,0,0));  ex.push_back(exo(0,0,0,6,NO));
    st.push_back(stm(0,0,0,0,1,0,0));  ex.push_back(exo(0,0,0,0,NO));
    st.push_back(IDLE_S);              ex.push_back(exo(0,0,0,0,NO));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i], ex[i]);
      want = exp_q.pop_front(); got = observed(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL bad_index step %0d got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_timeout();
    stim_t st[$]; out_t ex[$]; out_t got, want;
    // payment timeout on slot 0
    st.push_back(stm(0,1,0,0,0,0,0)); ex.push_back(exo(0,0,0,0,NO));
    st.push_back(stm(0,0,1,0,0,0,0)); ex.push_back(exo(0,0,0,0,NO));
    st.push_back(stm(0,0,1,0,0,0,0)); ex.push_back(exo(0,0,0,1,NO));
    repeat (4) begin st.push_back(IDLE_S); ex.push_back(exo(0,0,0,1,NO)); end
    st.push_back(IDLE_S);             ex.push_back(exo(0,0,1,0,NO));
    st.push_back(IDLE_S);             ex.push_back(exo(0,0,0,0,NO));
    // first-digit timeout
    st.push_back(stm(0,1,0,0,0,0,0)); ex.push_back(exo(0,0,0,0,NO));
    repeat (4) begin st.push_back(IDLE_S); ex.push_back(exo(0,0,0,0,NO)); end
    st.push_back(IDLE_S);             ex.push_back(exo(0,1,0,0,NO));
    st.push_back(IDLE_S);             ex.push_back(exo(0,0,0,0,NO));
    // second-digit timeout
    st.push_back(stm(0,1,0,0,0,0,0)); ex.push_back(exo(0,0,0,0,NO));
    st.push_back(stm(0,0,1,1,0,0,0)); ex.push_back(exo(0,0,0,0,NO));
    repeat (4) begin st.push_back(IDLE_S); ex.push_back(exo(0,0,0,0,NO)); end
    st.push_back(IDLE_S);             ex.push_back(exo(0,1,0,0,NO));
    // payment on the last allowed cycle, then vend timeout
    st.push_back(stm(0,1,0,0,0,0,0)); ex.push_back(exo(0,0,0,0,NO));
    st.push_back(stm(0,0,1,0,0,0,0)); ex.push_back(exo(0,0,0,0,NO));
    st.push_back(stm(0,0,1,0,0,0,0)); ex.push_back(exo(0,0,0,1,NO));
    repeat (4) begin st.push_back(IDLE_S); ex.push_back(exo(0,0,0,1,NO)); end
    st.push_back(stm(0,0,0,0,0,1,0)); ex.push_back(exo(1,0,0,1,NO));
    repeat (4) begin st.push_back(IDLE_S); ex.push_back(exo(1,0,0,1,NO)); end
    st.push_back(IDLE_S);             ex.push_back(exo(0,0,0,0,NO));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i], ex[i]);
      want = exp_q.pop_front(); got = observed(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL timeout step %0d got %h want %h", i, got, want);
      end
      if (i == 8) begin
        checks++;
        if (dut.stock_q[0] !== 4'd10) begin
          errors++; $display("FAIL timeout_stock0 got %0d want 10", dut.stock_q[0]);
        end
      end
    end
    checks++;
    if (dut.stock_q[0] !== 4'd9) begin
      errors++; $display("FAIL late_pay_stock0 got %0d want 9", dut.stock_q[0]);
    end
  endtask

  task automatic test_cancel();
    stim_t st[$]; out_t ex[$]; out_t got, want;
    st.push_back(stm(0,1,0,0,0,0,0)); ex.push_back(exo(0,0,0,0,NO));
    st.push_back(stm(0,0,1,0,0,0,0)); ex.push_back(exo(0,0,0,0,NO));
    st.push_back(stm(0,0,1,1,0,0,0)); ex.push_back(exo(0,0,0,1,NO));
    st.push_back(stm(0,0,0,0,1,1,0)); ex.push_back(exo(0,0,0,0,NO));
    st.push_back(IDLE_S);             ex.push_back(exo(0,0,0,0,NO));
    // cancel beats a key in DIGIT1; a stray key in IDLE is ignored
    st.push_back(stm(0,1,0,0,0,0,0)); ex.push_back(exo(0,0,0,0,NO));
    st.push_back(stm(0,0,1,1,1,0,0)); ex.push_back(exo(0,0,0,0,NO));
    st.push_back(stm(0,0,1,1,0,0,0)); ex.push_back(exo(0,0,0,0,NO));
    st.push_back(stm(0,1,0,0,0,0,0)); ex.push_back(exo(0,0,0,0,NO));
    st.push_back(stm(0,0,1,0,0,0,0)); ex.push_back(exo(0,0,0,0,NO));
    st.push_back(stm(0,0,1,5,0,0,0)); ex.push_back(exo(0,0,0,2,NO));
    st.push_back(stm(0,0,0,0,1,0,0)); ex.push_back(exo(0,0,0,0,NO));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i], ex[i]);
      want = exp_q.pop_front(); got = observed(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL cancel step %0d got %h want %h", i, got, want);
      end
    end
    checks++;
    if (dut.stock_q[1] !== 4'd10) begin
      errors++; $display("FAIL cancel_stock1 got %0d want 10", dut.stock_q[1]);
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[$]; out_t ex[$]; out_t got, want;
    logic [19:0] so_now, so_after;
    so_now = NO;
    for (int n = 0; n < 10; n++) begin
      so_after = (n == 9) ? 20'h00080 : NO;
      st.push_back(stm(0,1,0,0,0,0,0)); ex.push_back(exo(0,0,0,0,so_now));
      st.push_back(stm(0,0,1,0,0,0,0)); ex.push_back(exo(0,0,0,0,so_now));
      st.push_back(stm(0,0,1,7,0,0,0)); ex.push_back(exo(0,0,0,2,so_now));
      st.push_back(stm(0,0,0,0,0,1,0)); ex.push_back(exo(1,0,0,2,so_after));
      st.push_back(stm(0,0,0,0,0,0,1)); ex.push_back(exo(1,0,0,2,so_after));
      st.push_back(stm(0,0,0,0,0,0,0)); ex.push_back(exo(0,0,0,0,so_after));
      so_now = so_after;
    end
    st.push_back(stm(0,1,0,0,0,0,0)); ex.push_back(exo(0,0,0,0,20'h00080));
    st.push_back(stm(0,0,1,0,0,0,0)); ex.push_back(exo(0,0,0,0,20'h00080));
    st.push_back(stm(0,0,1,7,0,0,0)); ex.push_back(exo(0,1,0,0,20'h00080));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i], ex[i]);
      want = exp_q.pop_front(); got = observed(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL back_to_back step %0d got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_async_reset();
    stim_t st[$]; out_t ex[$]; out_t got, want;
    st.push_back(stm(0,1,0,0,0,0,0)); ex.push_back(exo(0,0,0,0,20'h00080));
    st.push_back(stm(0,0,1,1,0,0,0)); ex.push_back(exo(0,0,0,0,20'h00080));
    st.push_back(stm(0,0,1,2,0,0,0)); ex.push_back(exo(0,0,0,4,20'h00080));
    st.push_back(stm(0,0,0,0,0,1,0)); ex.push_back(exo(1,0,0,4,20'h00080));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i], ex[i]);
      want = exp_q.pop_front(); got = observed(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL async_reset step %0d got %h want %h", i, got, want);
      end
    end
    #2 RST_N = 1'b0;
    #1;
    got = observed(); checks++;
    if (got !== exo(0, 0, 0, 0, ALL)) begin
      errors++; $display("FAIL mid_vend_reset got %h want %h", got, exo(0, 0, 0, 0, ALL));
    end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    drive(stm(1,0,0,0,0,0,0), exo(0,0,0,0,NO));
    want = exp_q.pop_front(); got = observed(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL reload_after_reset got %h want %h", got, want);
    end
    checks++;
    if (dut.stock_q[12] !== 4'd10 || dut.stock_q[7] !== 4'd10) begin
      errors++; $display("FAIL reload_stock got %0d/%0d want 10/10", dut.stock_q[12], dut.stock_q[7]);
    end
  endtask

  initial begin
    test_reset();
    test_purchase();
    test_invalid_code();
    test_bad_index();
    test_timeout();
    test_cancel();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
